// File: rtl/mdio_master.sv
// MDIO (IEEE 802.3 clause 22) management master.
// Sends an optional all-ones preamble and then the 32-bit frame, MSB first.
// For a read (OP=10) it releases the line for the turnaround bits and then
// shifts in 16 data bits from the PHY. MDC has a period of 2*DIV clk cycles.
// Optional feature macro: MDIO_PRE_SUPPRESS_EN adds a PRE_SUPPRESS input.
// When that input is 1 at the start of a transaction, the preamble is skipped.
module mdio_master #(
  parameter int unsigned DIV     = 4,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
`ifdef MDIO_PRE_SUPPRESS_EN
  input  logic        PRE_SUPPRESS,
`endif
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned BIT_W = 6;
  localparam logic [CNT_W-1:0] RISE_CNT = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * DIV - 1);
  localparam logic [BIT_W-1:0] PRE_LAST = BIT_W'(PRE_LEN - 1);
  localparam logic [BIT_W-1:0] RD_SHIFT_LAST = BIT_W'(13);
  localparam logic [BIT_W-1:0] WR_SHIFT_LAST = BIT_W'(31);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SHIFT,
    TURN,
    READ,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [31:0]      sh;
  logic [15:0]      rx;
  logic             rd_op;
  logic             skip_pre_c;
  logic             start_rd_c;

  // Choose whether a new frame begins directly with the ST bits
`ifdef MDIO_PRE_SUPPRESS_EN
  assign skip_pre_c = PRE_SUPPRESS || (PRE_LEN == 0);
`else
  assign skip_pre_c = (PRE_LEN == 0);
`endif
  assign start_rd_c = (T_DATA[29:28] == 2'b10);

  // Frame sequencer: MDC generation, serial shift-out, read capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      rx       <= '0;
      rd_op    <= 1'b0;
      MDC      <= 1'b0;
      MDIO_OUT <= 1'b0;
      MDIO_OE  <= 1'b0;
      RD_DATA  <= '0;
      DATA_RDY <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DATA_RDY <= 1'b0;
          if (MDIO_START) begin
            BUSY    <= 1'b1;
            MDIO_OE <= 1'b1;
            MDC     <= 1'b0;
            cnt     <= '0;
            rd_op   <= start_rd_c;
            if (skip_pre_c) begin
              state    <= SHIFT;
              MDIO_OUT <= T_DATA[31];
              sh       <= {T_DATA[30:0], 1'b0};
              bit_cnt  <= start_rd_c ? RD_SHIFT_LAST : WR_SHIFT_LAST;
            end else begin
              state    <= PREAMBLE;
              MDIO_OUT <= 1'b1;
              sh       <= T_DATA;
              bit_cnt  <= PRE_LAST;
            end
          end
        end

        DONE: begin
          DATA_RDY <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          if (cnt != LAST_CNT) begin
            // Inside a bit period: raise MDC halfway and sample read data there
            cnt <= cnt + CNT_W'(1);
            if (cnt == RISE_CNT) begin
              MDC <= 1'b1;
              if (state == READ) rx <= {rx[14:0], MDIO_IN};
            end
          end else begin
            // Bit period boundary: MDC falls and the next bit is launched
            cnt <= '0;
            MDC <= 1'b0;
            case (state)
              PREAMBLE: begin
                if (bit_cnt == '0) begin
                  state    <= SHIFT;
                  MDIO_OUT <= sh[31];
                  sh       <= {sh[30:0], 1'b0};
                  bit_cnt  <= rd_op ? RD_SHIFT_LAST : WR_SHIFT_LAST;
                end else begin
                  bit_cnt  <= bit_cnt - BIT_W'(1);
                  MDIO_OUT <= 1'b1;
                end
              end
              SHIFT: begin
                if (bit_cnt == '0) begin
                  MDIO_OUT <= 1'b0;
                  MDIO_OE  <= 1'b0;
                  if (rd_op) begin
                    state   <= TURN;
                    bit_cnt <= BIT_W'(1);
                  end else begin
                    state    <= DONE;
                    BUSY     <= 1'b0;
                    DATA_RDY <= 1'b1;
                  end
                end else begin
                  bit_cnt  <= bit_cnt - BIT_W'(1);
                  MDIO_OUT <= sh[31];
                  sh       <= {sh[30:0], 1'b0};
                end
              end
              TURN: begin
                if (bit_cnt == '0) begin
                  state   <= READ;
                  bit_cnt <= BIT_W'(15);
                end else begin
                  bit_cnt <= bit_cnt - BIT_W'(1);
                end
              end
              READ: begin
                if (bit_cnt == '0) begin
                  state    <= DONE;
                  RD_DATA  <= rx;
                  BUSY     <= 1'b0;
                  DATA_RDY <= 1'b1;
                end else begin
                  bit_cnt <= bit_cnt - BIT_W'(1);
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: DIV=2 and DIV=1 instances, PRE_LEN=32.
// Optional feature macro: MDIO_PRE_SUPPRESS_EN (enables the preamble-suppress step).
module tb_mdio_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] tdata;
  logic        mdio_in;
  logic        pre_sup;

  logic        mdc0, out0, oe0, rdy0, busy0;
  logic [15:0] rd0;
  logic        mdc1, out1, oe1, rdy1, busy1;
  logic [15:0] rd1;

  logic        sel;
  logic        c_mdc, c_out, c_oe, c_rdy, c_busy;
  logic [15:0] c_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdio_master #(.DIV(2), .PRE_LEN(32)) u_dut0 (
    .clk(clk), .reset(reset), .MDIO_START(start), .T_DATA(tdata), .MDIO_IN(mdio_in),
`ifdef MDIO_PRE_SUPPRESS_EN
    .PRE_SUPPRESS(pre_sup),
`endif
    .MDC(mdc0), .MDIO_OUT(out0), .MDIO_OE(oe0), .RD_DATA(rd0), .DATA_RDY(rdy0), .BUSY(busy0)
  );

  mdio_master #(.DIV(1), .PRE_LEN(32)) u_dut1 (
    .clk(clk), .reset(reset), .MDIO_START(start), .T_DATA(tdata), .MDIO_IN(mdio_in),
`ifdef MDIO_PRE_SUPPRESS_EN
    .PRE_SUPPRESS(pre_sup),
`endif
    .MDC(mdc1), .MDIO_OUT(out1), .MDIO_OE(oe1), .RD_DATA(rd1), .DATA_RDY(rdy1), .BUSY(busy1)
  );

  // Route the instance under test to the common observation signals
  always_comb begin
    c_mdc  = sel ? mdc1  : mdc0;
    c_out  = sel ? out1  : out0;
    c_oe   = sel ? oe1   : oe0;
    c_rdy  = sel ? rdy1  : rdy0;
    c_busy = sel ? busy1 : busy0;
    c_rd   = sel ? rd1   : rd0;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // One transaction: drives START in cycle 0, then observes cycle by cycle.
  // Bit k is launched in cycle 1+2*div*k; PHY data is presented at the start of each read bit.
  task automatic run_txn(input logic [31:0] frame, input logic [15:0] phy, input int div,
                         input int nbits, input int pre_bits, input int restart_at,
                         input int reset_at, output logic [63:0] stream,
                         output logic [63:0] oe_bits, output int rdy_cyc,
                         output int rdy_cnt, output int bad_mdc, output int bad_busy);
    int cyc, k, ph, end_cyc, rd_start;
    bit aborted;
    stream   = '0;
    oe_bits  = '0;
    rdy_cyc  = -1;
    rdy_cnt  = 0;
    bad_mdc  = 0;
    bad_busy = 0;
    aborted  = 1'b0;
    end_cyc  = 1 + 2 * div * nbits;
    rd_start = pre_bits + 16;
    tdata    = frame;
    start    = 1'b1;
    step();
    cyc = 1;
    while (cyc <= end_cyc + 3 && !aborted) begin
      start = (cyc == restart_at);
      if (cyc == reset_at) begin
        reset = 1'b1;
        #1;
        check("rst_mdc",  64'(c_mdc),  64'd0);
        check("rst_out",  64'(c_out),  64'd0);
        check("rst_oe",   64'(c_oe),   64'd0);
        check("rst_busy", 64'(c_busy), 64'd0);
        check("rst_rd",   64'(c_rd),   64'd0);
        aborted = 1'b1;
      end else begin
        k  = (cyc - 1) / (2 * div);
        ph = (cyc - 1) % (2 * div);
        if (k < nbits) begin
          if (c_mdc !== (ph >= div)) bad_mdc++;
          if (c_busy !== 1'b1) bad_busy++;
          if (ph == 0) begin
            stream[nbits-1-k]  = c_out;
            oe_bits[nbits-1-k] = c_oe;
            if (k >= rd_start && k < rd_start + 16) mdio_in = phy[15-(k-rd_start)];
          end
        end else begin
          if (c_mdc !== 1'b0 || c_oe !== 1'b0) bad_mdc++;
          if (c_busy !== 1'b0) bad_busy++;
        end
        if (c_rdy === 1'b1) begin
          rdy_cnt++;
          rdy_cyc = cyc;
        end
      end
      step();
      cyc++;
    end
    start = 1'b0;
    if (aborted) begin
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (c_rdy === 1'b1) rdy_cnt++;
        step();
      end
    end
  endtask

  initial begin
    logic [63:0] stream, oe_bits;
    int rdy_cyc, rdy_cnt, bad_mdc, bad_busy;

    sel     = 1'b0;
    reset   = 1'b1;
    start   = 1'b0;
    tdata   = '0;
    mdio_in = 1'b0;
    pre_sup = 1'b0;
    step();
    step();
    check("reset_mdc",  64'(c_mdc),  64'd0);
    check("reset_out",  64'(c_out),  64'd0);
    check("reset_oe",   64'(c_oe),   64'd0);
    check("reset_rd",   64'(c_rd),   64'd0);
    check("reset_rdy",  64'(c_rdy),  64'd0);
    check("reset_busy", 64'(c_busy), 64'd0);
    reset = 1'b0;
    step();

    // Write: 32 preamble ones then the frame, OE held the whole time
    run_txn(32'h508A_BEEF, 16'h0, 2, 64, 32, -1, -1, stream, oe_bits, rdy_cyc, rdy_cnt, bad_mdc, bad_busy);
    check("wr_stream",   stream,  64'hFFFF_FFFF_508A_BEEF);
    check("wr_oe",       oe_bits, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wr_rdy_cyc",  64'(rdy_cyc), 64'd257);
    check("wr_rdy_cnt",  64'(rdy_cnt), 64'd1);
    check("wr_mdc",      64'(bad_mdc), 64'd0);
    check("wr_busy",     64'(bad_busy), 64'd0);
    check("wr_rd_data",  64'(c_rd), 64'h0);

    // Read: OE drops after bit 45, PHY returns 0xCAFE
    run_txn(32'h6088_0000, 16'hCAFE, 2, 64, 32, -1, -1, stream, oe_bits, rdy_cyc, rdy_cnt, bad_mdc, bad_busy);
    check("rd_stream",   stream,  64'hFFFF_FFFF_6088_0000);
    check("rd_oe",       oe_bits, 64'hFFFF_FFFF_FFFC_0000);
    check("rd_rdy_cyc",  64'(rdy_cyc), 64'd257);
    check("rd_rdy_cnt",  64'(rdy_cnt), 64'd1);
    check("rd_mdc",      64'(bad_mdc), 64'd0);
    check("rd_busy",     64'(bad_busy), 64'd0);
    check("rd_data",     64'(c_rd), 64'hCAFE);

    // Write with START re-pulsed mid-frame: ignored, RD_DATA keeps the last read value
    run_txn(32'h508A_BEEF, 16'h0, 2, 64, 32, 100, -1, stream, oe_bits, rdy_cyc, rdy_cnt, bad_mdc, bad_busy);
    check("rs_stream",   stream, 64'hFFFF_FFFF_508A_BEEF);
    check("rs_rdy_cyc",  64'(rdy_cyc), 64'd257);
    check("rs_rdy_cnt",  64'(rdy_cnt), 64'd1);
    check("rs_busy",     64'(bad_busy), 64'd0);
    check("rs_rd_keep",  64'(c_rd), 64'hCAFE);

    // Reset in the middle of a read: outputs clear at once, no completion pulse
    run_txn(32'h6088_0000, 16'hCAFE, 2, 64, 32, -1, 120, stream, oe_bits, rdy_cyc, rdy_cnt, bad_mdc, bad_busy);
    check("ab_rdy_cnt",  64'(rdy_cnt), 64'd0);
    check("ab_busy",     64'(c_busy), 64'd0);

    // Read after the abort runs a full frame
    run_txn(32'h6088_0000, 16'h1234, 2, 64, 32, -1, -1, stream, oe_bits, rdy_cyc, rdy_cnt, bad_mdc, bad_busy);
    check("ar_stream",   stream,  64'hFFFF_FFFF_6088_0000);
    check("ar_rdy_cyc",  64'(rdy_cyc), 64'd257);
    check("ar_rdy_cnt",  64'(rdy_cnt), 64'd1);
    check("ar_rd_data",  64'(c_rd), 64'h1234);

    // DIV=1 instance: MDC period of 2 clk cycles
    do_reset();
    sel = 1'b1;
    run_txn(32'h6088_0000, 16'h0001, 1, 64, 32, -1, -1, stream, oe_bits, rdy_cyc, rdy_cnt, bad_mdc, bad_busy);
    check("d1_stream",   stream,  64'hFFFF_FFFF_6088_0000);
    check("d1_oe",       oe_bits, 64'hFFFF_FFFF_FFFC_0000);
    check("d1_rdy_cyc",  64'(rdy_cyc), 64'd129);
    check("d1_mdc",      64'(bad_mdc), 64'd0);
    check("d1_rd_data",  64'(c_rd), 64'h0001);
    sel = 1'b0;

`ifdef MDIO_PRE_SUPPRESS_EN
    // Preamble suppressed: frame only, 32 bit periods
    do_reset();
    pre_sup = 1'b1;
    run_txn(32'h508A_BEEF, 16'h0, 2, 32, 0, -1, -1, stream, oe_bits, rdy_cyc, rdy_cnt, bad_mdc, bad_busy);
    pre_sup = 1'b0;
    check("ps_stream",   stream,  64'h0000_0000_508A_BEEF);
    check("ps_oe",       oe_bits, 64'h0000_0000_FFFF_FFFF);
    check("ps_rdy_cyc",  64'(rdy_cyc), 64'd129);
    check("ps_rdy_cnt",  64'(rdy_cnt), 64'd1);
    check("ps_mdc",      64'(bad_mdc), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
